// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the external byte-wide memory bridge.
package ext_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic {
    PH_STB = 1'b0,
    PH_REL = 1'b1
  } phase_t;

  // Width of the per-phase timeout counter; TIMEOUT_CYCLES must fit in it.
  localparam int TO_CNT_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low reset, used for the
// acknowledge coming back from the external device.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/ext_mem_bridge.sv
// CPU word request port to byte-wide external memory over a 4-phase strobe/ack
// handshake. Optional dead-device timeout enabled by defining EXT_MEM_TIMEOUT_EN.
module ext_mem_bridge
  import ext_mem_pkg::*;
#(
  parameter int DATA_BYTES     = 2,
  parameter int ADDR_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int MAX_BYTES     = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES,
  localparam int IDX_W         = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    req_we,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    addr_stb,
  output logic                    wr_stb,
  output logic                    rd_stb,
  output logic [IDX_W-1:0]        byte_idx,
  input  logic                    ext_ack,
  input  logic [7:0]              bus_in,
  output logic [7:0]              bus_out,
  output logic [7:0]              bus_oe
);

  state_t                  state_r, state_n;
  phase_t                  phase_r, phase_n;
  logic [IDX_W-1:0]        cnt_r, cnt_n, last_s;
  logic [8*ADDR_BYTES-1:0] addr_r, addr_n;
  logic [8*DATA_BYTES-1:0] wdata_r, wdata_n, rdata_r, rdata_n;
  logic                    we_r, we_n;
  logic                    ack_sync_s, timeout_s, err_n;
  logic [7:0]              addr_byte_s, wdata_byte_s, bus_out_n, bus_oe_n;
  logic                    req_ready_r, rsp_valid_r, rsp_err_r;
  logic                    addr_stb_r, wr_stb_r, rd_stb_r;
  logic [7:0]              bus_out_r, bus_oe_r;

  sync_2ff u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ext_ack),
    .q     (ack_sync_s)
  );

`ifdef EXT_MEM_TIMEOUT_EN
  logic [TO_CNT_W-1:0] tcnt_r;

  assign timeout_s = ((state_r == ST_ADDR) || (state_r == ST_WDATA) || (state_r == ST_RDATA))
                     && (tcnt_r == TO_CNT_W'(TIMEOUT_CYCLES));

  // Cycles spent in the current handshake phase; any phase or state change restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_r <= '0;
    end else if ((state_n != state_r) || (phase_n != phase_r)) begin
      tcnt_r <= '0;
    end else if (!timeout_s) begin
      tcnt_r <= tcnt_r + TO_CNT_W'(1);
    end else begin
      tcnt_r <= tcnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic: byte stages step STB -> REL on synced ack edges.
  always_comb begin
    state_n = state_r;
    phase_n = phase_r;
    cnt_n   = cnt_r;
    addr_n  = addr_r;
    wdata_n = wdata_r;
    we_n    = we_r;
    rdata_n = rdata_r;
    err_n   = 1'b0;
    if (state_r == ST_ADDR) begin
      last_s = IDX_W'(ADDR_BYTES - 1);
    end else begin
      last_s = IDX_W'(DATA_BYTES - 1);
    end
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_n = ST_ADDR;
          phase_n = PH_STB;
          cnt_n   = '0;
          addr_n  = req_addr;
          wdata_n = req_wdata;
          we_n    = req_we;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ADDR, ST_WDATA, ST_RDATA: begin
        if (timeout_s) begin
          state_n = ST_DONE;
          phase_n = PH_STB;
          cnt_n   = '0;
          rdata_n = '0;
          err_n   = 1'b1;
        end else if (phase_r == PH_STB) begin
          if (ack_sync_s) begin
            phase_n = PH_REL;
            if (state_r == ST_RDATA) begin
              for (int i = 0; i < DATA_BYTES; i++) begin
                rdata_n[8*i +: 8] = (cnt_r == IDX_W'(i)) ? bus_in : rdata_r[8*i +: 8];
              end
            end else begin
              rdata_n = rdata_r;
            end
          end else begin
            phase_n = PH_STB;
          end
        end else begin
          if (!ack_sync_s) begin
            phase_n = PH_STB;
            if (cnt_r == last_s) begin
              cnt_n = '0;
              if (state_r == ST_ADDR) begin
                state_n = we_r ? ST_WDATA : ST_RDATA;
              end else begin
                state_n = ST_DONE;
              end
            end else begin
              cnt_n = cnt_r + IDX_W'(1);
            end
          end else begin
            phase_n = PH_REL;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        phase_n = PH_STB;
      end
      default: begin
        state_n = ST_IDLE;
        phase_n = PH_STB;
        cnt_n   = '0;
      end
    endcase
  end

  // Pin values for the upcoming cycle, so the pins come straight from flops.
  always_comb begin
    addr_byte_s  = 8'h00;
    wdata_byte_s = 8'h00;
    for (int i = 0; i < ADDR_BYTES; i++) begin
      addr_byte_s = (cnt_n == IDX_W'(i)) ? addr_n[8*i +: 8] : addr_byte_s;
    end
    for (int j = 0; j < DATA_BYTES; j++) begin
      wdata_byte_s = (cnt_n == IDX_W'(j)) ? wdata_n[8*j +: 8] : wdata_byte_s;
    end
    case (state_n)
      ST_ADDR: begin
        bus_out_n = addr_byte_s;
        bus_oe_n  = 8'hFF;
      end
      ST_WDATA: begin
        bus_out_n = wdata_byte_s;
        bus_oe_n  = 8'hFF;
      end
      default: begin
        bus_out_n = 8'h00;
        bus_oe_n  = 8'h00;
      end
    endcase
  end

  // State, request capture and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      phase_r     <= PH_STB;
      cnt_r       <= '0;
      addr_r      <= '0;
      wdata_r     <= '0;
      we_r        <= 1'b0;
      rdata_r     <= '0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      addr_stb_r  <= 1'b0;
      wr_stb_r    <= 1'b0;
      rd_stb_r    <= 1'b0;
      bus_out_r   <= 8'h00;
      bus_oe_r    <= 8'h00;
    end else begin
      state_r     <= state_n;
      phase_r     <= phase_n;
      cnt_r       <= cnt_n;
      addr_r      <= addr_n;
      wdata_r     <= wdata_n;
      we_r        <= we_n;
      rdata_r     <= rdata_n;
      req_ready_r <= (state_n == ST_IDLE);
      rsp_valid_r <= (state_n == ST_DONE);
      rsp_err_r   <= err_n;
      addr_stb_r  <= (state_n == ST_ADDR)  && (phase_n == PH_STB);
      wr_stb_r    <= (state_n == ST_WDATA) && (phase_n == PH_STB);
      rd_stb_r    <= (state_n == ST_RDATA) && (phase_n == PH_STB);
      bus_out_r   <= bus_out_n;
      bus_oe_r    <= bus_oe_n;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = rsp_err_r;
  assign addr_stb  = addr_stb_r;
  assign wr_stb    = wr_stb_r;
  assign rd_stb    = rd_stb_r;
  assign byte_idx  = cnt_r;
  assign bus_out   = bus_out_r;
  assign bus_oe    = bus_oe_r;

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Scoreboard bench for ext_mem_bridge: default instance, a 3-address/4-data-byte
// instance, and a timeout instance when EXT_MEM_TIMEOUT_EN is defined.
module tb_ext_mem_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Default instance with an instantly acknowledging device.
  logic        req, req_we, req_ready, rsp_valid, rsp_err;
  logic [15:0] req_addr, req_wdata, rsp_rdata;
  logic        addr_stb, wr_stb, rd_stb, ext_ack;
  logic [0:0]  byte_idx;
  logic [7:0]  bus_in, bus_out, bus_oe;
  logic [7:0]  dev_rd [0:1];

  assign ext_ack = addr_stb | wr_stb | rd_stb;
  assign bus_in  = rd_stb ? dev_rd[byte_idx] : 8'h00;

  ext_mem_bridge dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .addr_stb(addr_stb), .wr_stb(wr_stb),
    .rd_stb(rd_stb), .byte_idx(byte_idx), .ext_ack(ext_ack), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe)
  );

  // Wide instance: device returns 01,02,03,04 by byte index.
  logic        w_req, w_req_we, w_req_ready, w_rsp_valid, w_rsp_err;
  logic [23:0] w_req_addr;
  logic [31:0] w_req_wdata, w_rsp_rdata;
  logic        w_addr_stb, w_wr_stb, w_rd_stb, w_ext_ack;
  logic [1:0]  w_byte_idx;
  logic [7:0]  w_bus_in, w_bus_out, w_bus_oe;

  assign w_ext_ack = w_addr_stb | w_wr_stb | w_rd_stb;
  assign w_bus_in  = w_rd_stb ? (8'h01 + {6'd0, w_byte_idx}) : 8'h00;

  ext_mem_bridge #(.DATA_BYTES(4), .ADDR_BYTES(3)) dut_w (
    .clk(clk), .reset(reset), .req(w_req), .req_we(w_req_we), .req_addr(w_req_addr),
    .req_wdata(w_req_wdata), .req_ready(w_req_ready), .rsp_valid(w_rsp_valid),
    .rsp_rdata(w_rsp_rdata), .rsp_err(w_rsp_err), .addr_stb(w_addr_stb), .wr_stb(w_wr_stb),
    .rd_stb(w_rd_stb), .byte_idx(w_byte_idx), .ext_ack(w_ext_ack), .bus_in(w_bus_in),
    .bus_out(w_bus_out), .bus_oe(w_bus_oe)
  );

  // Scoreboards: pins are {kind(1=addr,2=wr), byte}; responses are {err, rdata}.
  logic [9:0]  exp_pin_q[$];
  logic [16:0] exp_rsp_q[$];
  int          acc_q[$];
  int          acc_hist[$];
  int          rsp_hist[$];
  int          acc_count = 0;
  int          rsp_count = 0;
  logic        p_addr = 1'b0, p_wr = 1'b0, p_rd = 1'b0;

  logic [1:0]  w_idx_q[$];
  logic [31:0] w_rsp_q[$];
  int          w_acc_cyc = 0;
  int          w_acc = 0;
  int          w_rsp = 0;
  logic        wp_addr = 1'b0, wp_wr = 1'b0, wp_rd = 1'b0;

  // Default-instance monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if ((addr_stb && !p_addr) || (wr_stb && !p_wr) || (rd_stb && !p_rd)) begin
      check_eq("one_stb", $countones({addr_stb, wr_stb, rd_stb}), 1);
      if (rd_stb) begin
        check_eq("oe_rd", bus_oe, 8'h00);
      end else begin
        check_eq("oe_drv", bus_oe, 8'hFF);
        if (exp_pin_q.size() == 0) check_eq("pin_extra", exp_pin_q.size(), 1);
        else check_eq("pin", {(addr_stb ? 2'd1 : 2'd2), bus_out}, exp_pin_q.pop_front());
      end
    end
    if (req && req_ready && reset) begin
      acc_q.push_back(cyc);
      acc_hist.push_back(cyc);
      acc_count++;
    end
    if (rsp_valid) begin
      rsp_count++;
      rsp_hist.push_back(cyc);
      if (exp_rsp_q.size() == 0) begin
        check_eq("rsp_extra", exp_rsp_q.size(), 1);
      end else begin
        logic [16:0] e;
        e = exp_rsp_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata, e[15:0]);
        check_eq("rsp_err", rsp_err, e[16]);
      end
      // Inclusive span from the accept cycle to the rsp_valid cycle.
      if (acc_q.size() > 0) check_eq("latency", cyc - acc_q.pop_front() + 1, 26);
    end
    p_addr <= addr_stb;
    p_wr   <= wr_stb;
    p_rd   <= rd_stb;
  end

  // Wide-instance monitor.
  always @(negedge clk) begin
    if ((w_addr_stb && !wp_addr) || (w_wr_stb && !wp_wr) || (w_rd_stb && !wp_rd)) begin
      if (w_idx_q.size() == 0) check_eq("w_idx_extra", w_idx_q.size(), 1);
      else check_eq("w_idx", w_byte_idx, w_idx_q.pop_front());
    end
    if (w_req && w_req_ready && reset) begin
      w_acc_cyc = cyc;
      w_acc++;
    end
    if (w_rsp_valid) begin
      w_rsp++;
      if (w_rsp_q.size() == 0) check_eq("w_rsp_extra", w_rsp_q.size(), 1);
      else check_eq("w_rdata", w_rsp_rdata, w_rsp_q.pop_front());
      check_eq("w_latency", cyc - w_acc_cyc + 1, 6 * 7 + 2);
    end
    wp_addr <= w_addr_stb;
    wp_wr   <= w_wr_stb;
    wp_rd   <= w_rd_stb;
  end

`ifdef EXT_MEM_TIMEOUT_EN
  logic        t_req, t_req_we, t_req_ready, t_rsp_valid, t_rsp_err;
  logic [15:0] t_req_addr, t_req_wdata, t_rsp_rdata;
  logic        t_addr_stb, t_wr_stb, t_rd_stb;
  logic        t_ext_ack = 1'b0;
  logic [0:0]  t_byte_idx;
  logic [7:0]  t_bus_in = 8'h00;
  logic [7:0]  t_bus_out, t_bus_oe;

  ext_mem_bridge #(.TIMEOUT_CYCLES(15)) dut_t (
    .clk(clk), .reset(reset), .req(t_req), .req_we(t_req_we), .req_addr(t_req_addr),
    .req_wdata(t_req_wdata), .req_ready(t_req_ready), .rsp_valid(t_rsp_valid),
    .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err), .addr_stb(t_addr_stb), .wr_stb(t_wr_stb),
    .rd_stb(t_rd_stb), .byte_idx(t_byte_idx), .ext_ack(t_ext_ack), .bus_in(t_bus_in),
    .bus_out(t_bus_out), .bus_oe(t_bus_oe)
  );
`endif

  task automatic push_pins(input logic [1:0] kind, input logic [15:0] v);
    exp_pin_q.push_back({kind, v[7:0]});
    exp_pin_q.push_back({kind, v[15:8]});
  endtask

  // Issue one request on the default instance, then scramble the fields.
  task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d);
    int  base;
    logic got;
    base = acc_count;
    got  = 1'b0;
    @(posedge clk); #2;
    req_we = we; req_addr = a; req_wdata = d; req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (acc_count > base) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("accept", got, 1'b1);
    @(posedge clk); #2;
    req = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~d;
  endtask

  task automatic wait_rsp(input int target);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rsp_count >= target) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    check_eq("rsp_wait", got, 1'b1);
  endtask

  initial begin
    int   n;
    int   base;
    int   rbase;
    logic found;

    reset = 1'b0;
    req = 1'b0; req_we = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
    w_req = 1'b0; w_req_we = 1'b0; w_req_addr = 24'h0; w_req_wdata = 32'h0;
`ifdef EXT_MEM_TIMEOUT_EN
    t_req = 1'b0; t_req_we = 1'b0; t_req_addr = 16'h0; t_req_wdata = 16'h0;
`endif
    dev_rd[0] = 8'h00; dev_rd[1] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_ready", req_ready, 1'b1);
    check_eq("rst_valid", rsp_valid, 1'b0);
    check_eq("rst_stb", {addr_stb, wr_stb, rd_stb}, 3'b000);
    check_eq("rst_oe", bus_oe, 8'h00);
    check_eq("rst_out", bus_out, 8'h00);
    check_eq("rst_rdata", rsp_rdata, 16'h0000);
    check_eq("rst_idx", byte_idx, 1'b0);
    check_eq("rst_err", rsp_err, 1'b0);
    check_eq("w_rst_ready", w_req_ready, 1'b1);
    @(posedge clk); #2;
    reset = 1'b1;

    // Read 0x1234, device returns CD then AB.
    dev_rd[0] = 8'hCD; dev_rd[1] = 8'hAB;
    push_pins(2'd1, 16'h1234);
    exp_rsp_q.push_back({1'b0, 16'hABCD});
    do_req(1'b0, 16'h1234, 16'h0000);
    wait_rsp(1);

    // Write BEEF to 0x00FF; read data must stay ABCD.
    push_pins(2'd1, 16'h00FF);
    push_pins(2'd2, 16'hBEEF);
    exp_rsp_q.push_back({1'b0, 16'hABCD});
    do_req(1'b1, 16'h00FF, 16'hBEEF);
    wait_rsp(2);
    @(negedge clk); #1;
    check_eq("oe_after_done", bus_oe, 8'h00);
    check_eq("ready_after_done", req_ready, 1'b1);

    // Reset asserted during write data byte 1: no response.
    push_pins(2'd1, 16'hAA55);
    push_pins(2'd2, 16'h1357);
    n = rsp_count;
    do_req(1'b1, 16'hAA55, 16'h1357);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (wr_stb && (byte_idx == 1'b1)) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("wait_wr1", found, 1'b1);
    #1 reset = 1'b0;
    acc_q.delete();
    #1;
    check_eq("async_wr_stb", wr_stb, 1'b0);
    check_eq("async_oe", bus_oe, 8'h00);
    check_eq("async_stb", {addr_stb, rd_stb}, 2'b00);
    repeat (3) @(posedge clk);
    #2;
    check_eq("mid_rst_rdata", rsp_rdata, 16'h0000);
    check_eq("pins_left", exp_pin_q.size(), 0);
    reset = 1'b1;

    // Normal read after reset.
    dev_rd[0] = 8'h11; dev_rd[1] = 8'h22;
    push_pins(2'd1, 16'hC3C3);
    exp_rsp_q.push_back({1'b0, 16'h2211});
    do_req(1'b0, 16'hC3C3, 16'h0000);
    wait_rsp(n + 1);
    check_eq("no_rsp_on_reset", rsp_count, n + 1);

    // req held high across two transactions.
    dev_rd[0] = 8'h77; dev_rd[1] = 8'h66;
    for (int k = 0; k < 2; k++) begin
      push_pins(2'd1, 16'h0F0F);
      exp_rsp_q.push_back({1'b0, 16'h6677});
    end
    base  = acc_count;
    rbase = rsp_count;
    @(posedge clk); #2;
    req_we = 1'b0; req_addr = 16'h0F0F; req_wdata = 16'h0000; req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (acc_count >= base + 2) break;
    end
    @(posedge clk); #2;
    req = 1'b0;
    wait_rsp(rbase + 2);
    check_eq("held_accepts", acc_count - base, 2);
    if (acc_hist.size() > base + 1 && rsp_hist.size() > rbase)
      check_eq("b2b_gap", acc_hist[base + 1] - rsp_hist[rbase], 1);
    else
      check_eq("b2b_hist", acc_hist.size() + rsp_hist.size(), base + rbase + 3);

    // Wide instance read: byte_idx 0..2 then 0..3, data 04030201.
    for (int i = 0; i < 3; i++) w_idx_q.push_back(2'(i));
    for (int i = 0; i < 4; i++) w_idx_q.push_back(2'(i));
    w_rsp_q.push_back(32'h04030201);
    @(posedge clk); #2;
    w_req_addr = 24'h123456; w_req_we = 1'b0; w_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (w_acc > 0) break;
    end
    @(posedge clk); #2;
    w_req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (w_rsp > 0) break;
      @(negedge clk); #1;
    end
    check_eq("w_rsp_seen", w_rsp, 1);
    check_eq("w_idx_left", w_idx_q.size(), 0);

`ifdef EXT_MEM_TIMEOUT_EN
    // Device never acknowledges: expect an error response.
    @(posedge clk); #2;
    t_req_addr = 16'h4321; t_req = 1'b1;
    @(posedge clk); #2;
    t_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (t_rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t_rsp_seen", found, 1'b1);
    check_eq("t_err", t_rsp_err, 1'b1);
    check_eq("t_rdata", t_rsp_rdata, 16'h0000);
    check_eq("t_stb", {t_addr_stb, t_wr_stb, t_rd_stb}, 3'b000);
    check_eq("t_oe", t_bus_oe, 8'h00);
    @(negedge clk); #1;
    check_eq("t_ready_next", t_req_ready, 1'b1);
`endif

    check_eq("rsp_left", exp_rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
